cv32e40p_ldm_ctrl: RTL and testbench

//  Sequencer and alarm manager for one cv32e40p_ldm_detector instance.
//  - Drives the detector's init/decrement strobes from core retirement and basic-block-end events.
//  - Reloads the detector when monitoring is off or suspended (debug).
//  - Latches detector alarms and escalates repeated alarms to a fatal, reset-only condition.
//  - Sits between the core's retire/debug signals, the detector, and the system alarm/irq logic.

---
 rtl/cv32e40p_ldm_ctrl_if.sv | 33 +++
 rtl/cv32e40p_ldm_ctrl.sv | 108 ++++++++++
 tb/tb_cv32e40p_ldm_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_ldm_ctrl_if.sv
// Handshake bundle between the LDM controller, the core's retire/debug signals,
// the detector and the system alarm/irq logic.
interface cv32e40p_ldm_ctrl_if #(
   parameter int ALARM_THRESHOLD = 3
);
   localparam int W = $clog2(ALARM_THRESHOLD + 1);

   logic         enable_i;
   logic         instr_retire_i;
   logic         bb_end_i;
   logic         debug_mode_i;
   logic         det_alarm_i;
   logic         clr_req_i;
   logic         det_init_o;
   logic         det_decrement_o;
   logic         alarm_irq_o;
   logic         fatal_o;
   logic         clr_ack_o;
   logic [W-1:0] alarm_count_o;
   logic [2:0]   state_o;

   modport master (
      output enable_i, instr_retire_i, bb_end_i, debug_mode_i, det_alarm_i, clr_req_i,
      input  det_init_o, det_decrement_o, alarm_irq_o, fatal_o, clr_ack_o,
             alarm_count_o, state_o
   );

   modport slave (
      input  enable_i, instr_retire_i, bb_end_i, debug_mode_i, det_alarm_i, clr_req_i,
      output det_init_o, det_decrement_o, alarm_irq_o, fatal_o, clr_ack_o,
             alarm_count_o, state_o
   );
endinterface

// File: rtl/cv32e40p_ldm_ctrl.sv
// Sequencer and alarm manager for one cv32e40p_ldm_detector: drives its strobes,
// latches its alarms and escalates repeated alarms to a reset-only FATAL state.
module cv32e40p_ldm_ctrl #(
   parameter int ALARM_THRESHOLD = 3,
   parameter int ARM_CYCLES      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   cv32e40p_ldm_ctrl_if.slave    bus
);
   localparam int W = $clog2(ALARM_THRESHOLD + 1);
   localparam logic [3:0] ARM_LAST = 4'(ARM_CYCLES - 1);
   localparam logic [W:0] THRESH   = (W+1)'(ALARM_THRESHOLD);

   typedef enum logic [2:0] {
      S_DISABLED = 3'd0,
      S_ARMING   = 3'd1,
      S_MONITOR  = 3'd2,
      S_ALARM    = 3'd3,
      S_FATAL    = 3'd4
   } state_e;

   state_e       state_q, state_d;
   logic [3:0]   arm_cnt_q, arm_cnt_d;
   logic [W-1:0] count_q, count_d;
   logic         clr_ack_q, clr_ack_d;
   logic         irq_q, irq_d;
   logic         fatal_q, fatal_d;
   logic [W:0]   count_inc;

   assign count_inc = {1'b0, count_q} + 1'b1;

   // Outside active monitoring both strobes are held high so the detector keeps reloading.
   always_comb begin
      bus.det_init_o      = 1'b1;
      bus.det_decrement_o = 1'b1;
      if (!rst && state_q == S_MONITOR && !bus.debug_mode_i) begin
         bus.det_decrement_o = bus.instr_retire_i;
         bus.det_init_o      = bus.instr_retire_i & bus.bb_end_i;
      end
   end

   always_comb begin
      state_d   = state_q;
      arm_cnt_d = arm_cnt_q;
      count_d   = count_q;
      clr_ack_d = 1'b0;
      unique case (state_q)
         S_DISABLED: begin
            if (bus.enable_i) begin
               state_d   = S_ARMING;
               arm_cnt_d = '0;
            end
         end
         S_ARMING: begin
            arm_cnt_d = arm_cnt_q + 4'd1;
            if (!bus.enable_i)             state_d = S_DISABLED;
            else if (arm_cnt_q == ARM_LAST) state_d = S_MONITOR;
         end
         S_MONITOR: begin
            // The alarm outranks both debug suspension and disable in the same cycle.
            if (bus.det_alarm_i) begin
               count_d = (count_inc >= THRESH) ? THRESH[W-1:0] : count_inc[W-1:0];
               state_d = (count_inc >= THRESH) ? S_FATAL : S_ALARM;
            end else if (!bus.enable_i) begin
               state_d = S_DISABLED;
            end
         end
         S_ALARM: begin
            if (!bus.enable_i) begin
               state_d = S_DISABLED;
            end else if (bus.clr_req_i) begin
               state_d   = S_ARMING;
               arm_cnt_d = '0;
               clr_ack_d = 1'b1;
            end
         end
         S_FATAL: state_d = S_FATAL;
         default: state_d = S_DISABLED;
      endcase
      irq_d   = (state_d == S_ALARM);
      fatal_d = (state_d == S_FATAL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_DISABLED;
         arm_cnt_q <= '0;
         count_q   <= '0;
         clr_ack_q <= 1'b0;
         irq_q     <= 1'b0;
         fatal_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         arm_cnt_q <= arm_cnt_d;
         count_q   <= count_d;
         clr_ack_q <= clr_ack_d;
         irq_q     <= irq_d;
         fatal_q   <= fatal_d;
      end
   end

   assign bus.alarm_irq_o   = irq_q;
   assign bus.fatal_o       = fatal_q;
   assign bus.clr_ack_o     = clr_ack_q;
   assign bus.alarm_count_o = count_q;
   assign bus.state_o       = state_q;
endmodule

// File: tb/tb_cv32e40p_ldm_ctrl.sv
// Directed scenarios followed by random traffic for cv32e40p_ldm_ctrl, checked
// against a cycle-level behavioural model of the controller.
module tb_cv32e40p_ldm_ctrl;
   localparam int TH = 3;
   localparam int AC = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cv32e40p_ldm_ctrl_if #(.ALARM_THRESHOLD(TH)) bus ();
   cv32e40p_ldm_ctrl #(.ALARM_THRESHOLD(TH), .ARM_CYCLES(AC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Model: mode 0..4 = disabled/arming/monitor/alarm/fatal; arm_left counts remaining arming cycles.
   int mode     = 0;
   int arm_left = 0;
   int alarms   = 0;
   int ack      = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_update(input bit r, input bit en, input bit al, input bit clr);
      if (r) begin
         mode = 0; arm_left = 0; alarms = 0; ack = 0;
         return;
      end
      ack = 0;
      case (mode)
         0: if (en) begin mode = 1; arm_left = AC; end
         1: if (!en) mode = 0;
            else begin
               arm_left = arm_left - 1;
               if (arm_left == 0) mode = 2;
            end
         2: if (al) begin
               mode   = (alarms + 1 >= TH) ? 4 : 3;
               alarms = (alarms + 1 > TH) ? TH : alarms + 1;
            end else if (!en) mode = 0;
         3: if (!en) mode = 0;
            else if (clr) begin mode = 1; arm_left = AC; ack = 1; end
         default: ;
      endcase
   endtask

   task automatic step(input bit r, input bit en, input bit ret, input bit bb,
                       input bit dbg, input bit al, input bit clr);
      bit active;
      rst = r;
      bus.enable_i = en; bus.instr_retire_i = ret; bus.bb_end_i = bb;
      bus.debug_mode_i = dbg; bus.det_alarm_i = al; bus.clr_req_i = clr;
      #1;
      active = !r && mode == 2 && !dbg;
      chk("det_decrement", bus.det_decrement_o, active ? ret : 1'b1);
      chk("det_init", bus.det_init_o, active ? (ret & bb) : 1'b1);
      @(posedge clk);
      model_update(r, en, al, clr);
      @(negedge clk);
      chk("state", bus.state_o, mode);
      chk("alarm_irq", bus.alarm_irq_o, mode == 3);
      chk("fatal", bus.fatal_o, mode == 4);
      chk("clr_ack", bus.clr_ack_o, ack);
      chk("alarm_count", bus.alarm_count_o, alarms);
   endtask

   initial begin
      // Reset
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 1, 0, 1, 1);
      chk("rst_state", bus.state_o, 0);
      chk("rst_count", bus.alarm_count_o, 0);
      chk("rst_irq", bus.alarm_irq_o, 0);

      // 1: arm then clean basic blocks
      step(0, 1, 0, 0, 0, 0, 0);
      chk("arm_state", bus.state_o, 1);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("monitor_state", bus.state_o, 2);
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < 3; j++) step(0, 1, 1, 0, 0, 0, 0);
         step(0, 1, 1, 1, 0, 0, 0);
      end
      // bb_end without retire is a no-op
      step(0, 1, 0, 1, 0, 0, 0);
      chk("bb_monitor", bus.state_o, 2);

      // 2: long basic block -> alarm
      for (int j = 0; j < 4; j++) step(0, 1, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1, 0);
      chk("alarm_state", bus.state_o, 3);
      chk("alarm_irq1", bus.alarm_irq_o, 1);
      chk("alarm_cnt1", bus.alarm_count_o, 1);

      // 3: clear -> ack for one cycle, rearm
      step(0, 1, 0, 0, 0, 1, 1);
      chk("ack_hi", bus.clr_ack_o, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      chk("ack_lo", bus.clr_ack_o, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("rearm_mon", bus.state_o, 2);
      chk("rearm_irq", bus.alarm_irq_o, 0);

      // 4: escalate to FATAL
      step(0, 1, 0, 0, 0, 1, 0);
      chk("alarm_cnt2", bus.alarm_count_o, 2);
      step(0, 1, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1, 0);
      chk("fatal_state", bus.state_o, 4);
      chk("fatal_out", bus.fatal_o, 1);
      chk("fatal_cnt", bus.alarm_count_o, 3);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1, 1);
      chk("fatal_hold", bus.state_o, 4);
      chk("fatal_noack", bus.clr_ack_o, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("fatal_rst", bus.state_o, 0);
      chk("fatal_rst_cnt", bus.alarm_count_o, 0);

      // 5: debug suspension, then stall alarm
      for (int j = 0; j < 3; j++) step(0, 1, 0, 0, 0, 0, 0);
      for (int j = 0; j < 20; j++) step(0, 1, 0, 0, 1, 0, 0);
      chk("dbg_mon", bus.state_o, 2);
      for (int j = 0; j < 8; j++) step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1, 0);
      chk("stall_alarm", bus.state_o, 3);

      // 6: alarm beats debug and disable; reset out of ALARM
      step(0, 1, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1, 0);
      chk("prio_alarm", bus.state_o, 3);
      chk("prio_cnt", bus.alarm_count_o, 2);
      step(1, 1, 0, 0, 0, 0, 0);
      chk("alarm_rst", bus.alarm_irq_o, 0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 15) != 0),
              $urandom_range(0, 1), $urandom_range(0, 1),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
